// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
//   DEF_DATA_W / DEF_NUM_REGS : default geometry
//   ZERO_IDX                  : index of the hard-wired zero register
//   reg_addr_t                : wide enough to hold any index and NUM_REGS itself (<= 64)
//   clog2()                   : ceiling log2, used to derive address width
package regfile_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int ZERO_IDX     = 0;

  typedef logic [6:0] reg_addr_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = int'(i) + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard for the register file.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   wr_acc_i      : per-port "write accepted" (already range/zero/reset qualified)
//   wr_addr_i     : write addresses, port j at slice j
//   sb_set_i      : mark sb_addr_i pending
//   sb_addr_i     : register to mark
//   busy_o        : busy bit per register
//   sb_err_o      : registered pulse, set issued to a register already pending
//   busy_cnt_o    : registered population count of busy_o
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  parameter int AW       = clog2(NUM_REGS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_WR-1:0]    wr_acc_i,
  input  logic [NUM_WR*AW-1:0] wr_addr_i,
  input  logic                 sb_set_i,
  input  logic [AW-1:0]        sb_addr_i,
  output logic [NUM_REGS-1:0]  busy_o,
  output logic                 sb_err_o,
  output logic [AW:0]          busy_cnt_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                sb_err_q, sb_err_d;
  logic [AW:0]         busy_cnt_q, busy_cnt_d;
  logic                sb_ok;
  logic                sb_hit_wr;

  always_comb begin
    sb_ok = sb_set_i
         && (reg_addr_t'(sb_addr_i) < reg_addr_t'(NUM_REGS))
         && !(ZERO_REG != 0 && reg_addr_t'(sb_addr_i) == reg_addr_t'(ZERO_IDX));

    busy_d    = busy_q;
    sb_hit_wr = 1'b0;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      if (wr_acc_i[j]) begin
        busy_d[wr_addr_i[j*AW +: AW]] = 1'b0;
        if (wr_addr_i[j*AW +: AW] == sb_addr_i) sb_hit_wr = 1'b1;
      end
    end
    // Set applied after clears: a same-cycle issue is younger than the retiring write.
    if (sb_ok) busy_d[sb_addr_i] = 1'b1;

    sb_err_d = sb_ok && busy_q[sb_addr_i] && !sb_hit_wr;

    busy_cnt_d = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[r]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q     <= '0;
      sb_err_q   <= 1'b0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      sb_err_q   <= sb_err_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign sb_err_o   = sb_err_q;
  assign busy_cnt_o = busy_cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional write bypass and busy scoreboard.
//   clk, reset : clock, asynchronous active-low reset
//   rd_addr    : NUM_RD read addresses          rd_data : combinational read data
//   rd_busy    : read register has pending write (masked when forwarded)
//   wr_en/wr_addr/wr_data : NUM_WR write ports, higher index wins
//   sb_set/sb_addr : mark register pending      sb_err : set hit busy register
//   busy_cnt   : number of pending registers
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     sb_set,
  input  logic [AW-1:0]            sb_addr,
  output logic                     sb_err,
  output logic [AW:0]              busy_cnt
);

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (reg_addr_t'(a) < reg_addr_t'(NUM_REGS))
        && !(ZERO_REG != 0 && reg_addr_t'(a) == reg_addr_t'(ZERO_IDX));
  endfunction

  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic [NUM_WR-1:0]   wr_acc;
  logic [NUM_REGS-1:0] busy;

  // Qualifying with reset keeps the bypass path quiet so reads show the zeroed array.
  always_comb begin
    wr_acc = '0;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      wr_acc[j] = reset && wr_en[j] && addr_ok(wr_addr[j*AW +: AW]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) mem_q[r] <= '0;
    end else begin
      // Ascending order: the last assignment (highest port) takes effect.
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_acc[j]) mem_q[wr_addr[j*AW +: AW]] <= wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    logic [AW-1:0] a;
    logic          fwd;
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      a   = rd_addr[i*AW +: AW];
      fwd = 1'b0;
      if (addr_ok(a)) begin
        rd_data[i*DATA_W +: DATA_W] = mem_q[a];
        if (BYPASS != 0) begin
          for (int unsigned j = 0; j < NUM_WR; j++) begin
            if (wr_acc[j] && wr_addr[j*AW +: AW] == a) begin
              rd_data[i*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
              fwd = 1'b1;
            end
          end
        end
        rd_busy[i] = busy[a] && !fwd;
      end
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_sb (
    .clk_i      (clk),
    .rst_ni     (reset),
    .wr_acc_i   (wr_acc),
    .wr_addr_i  (wr_addr),
    .sb_set_i   (sb_set),
    .sb_addr_i  (sb_addr),
    .busy_o     (busy),
    .sb_err_o   (sb_err),
    .busy_cnt_o (busy_cnt)
  );

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: defaults (32 regs, 2 rd, 2 wr, bypass, zero reg)
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic [1:0]  a_wr_en;
  logic [9:0]  a_wr_addr;
  logic [63:0] a_wr_data;
  logic        a_sb_set;
  logic [4:0]  a_sb_addr;
  logic        a_sb_err;
  logic [5:0]  a_busy_cnt;

  // Instance B: 24 regs, 4 rd ports, no bypass
  logic [19:0]  b_rd_addr;
  logic [127:0] b_rd_data;
  logic [3:0]   b_rd_busy;
  logic [1:0]   b_wr_en;
  logic [9:0]   b_wr_addr;
  logic [63:0]  b_wr_data;
  logic         b_sb_set;
  logic [4:0]   b_sb_addr;
  logic         b_sb_err;
  logic [5:0]   b_busy_cnt;

  regfile_mp u_dut_a (
    .clk(clk), .reset(reset),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .sb_set(a_sb_set), .sb_addr(a_sb_addr), .sb_err(a_sb_err), .busy_cnt(a_busy_cnt)
  );

  regfile_mp #(.NUM_REGS(24), .NUM_RD(4), .BYPASS(0)) u_dut_b (
    .clk(clk), .reset(reset),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .sb_set(b_sb_set), .sb_addr(b_sb_addr), .sb_err(b_sb_err), .busy_cnt(b_busy_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic idle();
    a_wr_en = '0; a_sb_set = 1'b0;
    b_wr_en = '0; b_sb_set = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    a_rd_addr = '0; a_wr_addr = '0; a_wr_data = '0; a_sb_addr = '0;
    b_rd_addr = '0; b_wr_addr = '0; b_wr_data = '0; b_sb_addr = '0;
    #2;
    check("rst_rd",  a_rd_data,  0);
    check("rst_cnt", a_busy_cnt, 0);
    check("rst_err", a_sb_err,   0);
    tick();
    reset = 1'b1;

    // Write priority: both ports to r7, port 1 wins
    a_wr_en = 2'b11; a_wr_addr = {5'd7, 5'd7};
    a_wr_data = {32'h22222222, 32'h11111111};
    a_rd_addr = {5'd7, 5'd7};
    #1 check("prio_bypass", a_rd_data, {2{32'h22222222}});
    tick(); idle();
    #1 check("prio_stored", a_rd_data, {2{32'h22222222}});

    // Zero register: writes and sets ignored
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd0}; a_wr_data = {32'h0, 32'hFFFFFFFF};
    a_sb_set = 1'b1; a_sb_addr = 5'd0;
    a_rd_addr = {5'd7, 5'd0};
    #1 check("zero_bypass", a_rd_data, {32'h22222222, 32'h0});
    tick(); idle();
    #1 check("zero_rd",   a_rd_data, {32'h22222222, 32'h0});
    check("zero_busy", a_rd_busy,  0);
    check("zero_cnt",  a_busy_cnt, 0);
    check("zero_err",  a_sb_err,   0);

    // Scoreboard set then clear by write
    a_sb_set = 1'b1; a_sb_addr = 5'd9;
    tick(); idle();
    a_rd_addr = {5'd9, 5'd0};
    #1 check("sb_busy", a_rd_busy, 2'b10);
    check("sb_cnt1", a_busy_cnt, 1);
    check("sb_err0", a_sb_err, 0);
    a_wr_en = 2'b10; a_wr_addr = {5'd9, 5'd0}; a_wr_data = {32'h1234, 32'h0};
    #1 check("sb_fwd_busy", a_rd_busy, 2'b00);
    check("sb_fwd_data", a_rd_data, {32'h1234, 32'h0});
    tick(); idle();
    #1 check("sb_clr_cnt",  a_busy_cnt, 0);
    check("sb_clr_busy", a_rd_busy, 2'b00);
    check("sb_clr_data", a_rd_data, {32'h1234, 32'h0});

    // Set/clear collision on r3
    a_sb_set = 1'b1; a_sb_addr = 5'd3;
    tick(); idle();
    a_rd_addr = {5'd9, 5'd3};
    #1 check("col_cnt1", a_busy_cnt, 1);
    check("col_busy1", a_rd_busy, 2'b01);
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd3}; a_wr_data = {32'h0, 32'h55};
    a_sb_set = 1'b1; a_sb_addr = 5'd3;
    #1 check("col_fwd_busy", a_rd_busy, 2'b00);
    tick(); idle();
    #1 check("col_busy2", a_rd_busy, 2'b01);
    check("col_cnt2",  a_busy_cnt, 1);
    check("col_err0",  a_sb_err, 0);
    check("col_data",  a_rd_data, {32'h1234, 32'h55});
    a_sb_set = 1'b1; a_sb_addr = 5'd3;
    tick(); idle();
    #1 check("dup_err1", a_sb_err, 1);
    check("dup_cnt",  a_busy_cnt, 1);
    tick();
    check("dup_err_clr", a_sb_err, 0);

    // Reset mid-run
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd5}; a_wr_data = {32'h0, 32'hDEADBEEF};
    tick(); idle();
    a_rd_addr = {5'd7, 5'd5};
    #1 check("pre_rst_rd", a_rd_data, {32'h22222222, 32'hDEADBEEF});
    reset = 1'b0;
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd5}; a_wr_data = {32'h0, 32'h99};
    #1 check("in_rst_rd", a_rd_data,  0);
    check("in_rst_cnt",  a_busy_cnt, 0);
    check("in_rst_err",  a_sb_err,   0);
    check("in_rst_busy", a_rd_busy,  0);
    tick(); idle();
    reset = 1'b1;
    #1 check("post_rst_rd",  a_rd_data,  0);
    check("post_rst_cnt", a_busy_cnt, 0);

    // Instance B: out-of-range and no-bypass latency
    b_wr_en = 2'b11; b_wr_addr = {5'd23, 5'd30}; b_wr_data = {32'h77, 32'hABCD};
    b_sb_set = 1'b1; b_sb_addr = 5'd30;
    b_rd_addr = {5'd23, 5'd30, 5'd0, 5'd30};
    #1 check("b_nobypass", b_rd_data, 0);
    check("b_busy0", b_rd_busy, 0);
    tick(); idle();
    #1 check("b_stored", b_rd_data, {32'h77, 96'h0});
    check("b_oor_cnt", b_busy_cnt, 0);
    check("b_err0", b_sb_err, 0);
    b_sb_set = 1'b1; b_sb_addr = 5'd23;
    tick(); idle();
    #1 check("b_busy23", b_rd_busy, 4'b1000);
    check("b_cnt1", b_busy_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
